// File: rtl/pipe_front_regs_if.sv
// Handshake/data bundle between the pipeline front end and its
// surroundings: hazard/redirect controls in, PC and stage registers out.
interface pipe_front_regs_if;
  logic        pc_write;
  logic        ifid_write;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_if;
  logic [11:0] id_ctrl;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;

  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [11:0] idex_ctrl;
  logic [4:0]  idex_rt;
  logic [4:0]  idex_rd;
  logic        idex_valid;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic        misalign;

  // Drives the controls and observes the pipeline registers.
  modport master (
    output pc_write, ifid_write, stall, flush, redirect_valid, redirect_target,
           instr_if, id_ctrl, id_rt, id_rd,
    input  pc, ifid_instr, ifid_pc4, ifid_valid, idex_ctrl, idex_rt, idex_rd,
           idex_valid, stall_cnt, flush_cnt, misalign
  );

  // The pipeline front end itself.
  modport slave (
    input  pc_write, ifid_write, stall, flush, redirect_valid, redirect_target,
           instr_if, id_ctrl, id_rt, id_rd,
    output pc, ifid_instr, ifid_pc4, ifid_valid, idex_ctrl, idex_rt, idex_rd,
           idex_valid, stall_cnt, flush_cnt, misalign
  );
endinterface

// File: rtl/pipe_front_regs.sv
// Pipeline front end: PC register, IF/ID and ID/EX stage registers with
// stall/flush handling, saturating hazard counters and a sticky flag for
// misaligned redirect targets. All outputs come straight from flops.
module pipe_front_regs #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst,
  pipe_front_regs_if.slave bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [11:0] idex_ctrl_q, idex_ctrl_d;
  logic [4:0]  idex_rt_q, idex_rt_d;
  logic [4:0]  idex_rd_q, idex_rd_d;
  logic        idex_valid_q, idex_valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        misalign_q, misalign_d;

  logic [31:0] pc_plus4;
  logic        redirect_taken;

  // Stall beats flush, so a redirect during a stall is dropped, not deferred.
  assign pc_plus4       = pc_q + 32'd4;
  assign redirect_taken = !bus.stall && bus.flush && bus.redirect_valid;

  // PC next-state and misalign tracking.
  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    if (bus.stall) begin
      pc_d = pc_q;
    end else if (redirect_taken) begin
      pc_d = {bus.redirect_target[31:2], 2'b00};
      if (bus.redirect_target[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else if (bus.pc_write) begin
      pc_d = pc_plus4;
    end
  end

  // IF/ID next-state: hold on stall, squash on flush, else load when enabled.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    if (bus.stall) begin
      ifid_valid_d = ifid_valid_q;
    end else if (bus.flush) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc4_d   = 32'd0;
      ifid_valid_d = 1'b0;
    end else if (bus.ifid_write) begin
      ifid_instr_d = bus.instr_if;
      ifid_pc4_d   = pc_plus4;
      ifid_valid_d = 1'b1;
    end
  end

  // ID/EX next-state: bubble on stall or flush, else pass decode results.
  always_comb begin
    idex_ctrl_d  = bus.id_ctrl;
    idex_rt_d    = bus.id_rt;
    idex_rd_d    = bus.id_rd;
    idex_valid_d = ifid_valid_q;
    if (bus.stall || bus.flush) begin
      idex_ctrl_d  = 12'd0;
      idex_rt_d    = 5'd0;
      idex_rd_d    = 5'd0;
      idex_valid_d = 1'b0;
    end
  end

  // Saturating event counters; a flush hidden by a stall is not counted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (bus.flush && !bus.stall && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
      idex_ctrl_q  <= 12'd0;
      idex_rt_q    <= 5'd0;
      idex_rd_q    <= 5'd0;
      idex_valid_q <= 1'b0;
      stall_cnt_q  <= 16'd0;
      flush_cnt_q  <= 16'd0;
      misalign_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      idex_ctrl_q  <= idex_ctrl_d;
      idex_rt_q    <= idex_rt_d;
      idex_rd_q    <= idex_rd_d;
      idex_valid_q <= idex_valid_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      misalign_q   <= misalign_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.ifid_instr = ifid_instr_q;
  assign bus.ifid_pc4   = ifid_pc4_q;
  assign bus.ifid_valid = ifid_valid_q;
  assign bus.idex_ctrl  = idex_ctrl_q;
  assign bus.idex_rt    = idex_rt_q;
  assign bus.idex_rd    = idex_rd_q;
  assign bus.idex_valid = idex_valid_q;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
  assign bus.misalign   = misalign_q;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Directed bench for pipe_front_regs: fetch, load-use stall, branch flush,
// stall/flush collision, misaligned redirect, PC wrap, counter saturation
// and asynchronous reset in the middle of a stall.
module tb_pipe_front_regs;
  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  pipe_front_regs_if bus ();

  pipe_front_regs #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_pc"},        bus.pc,                 32'h0);
    chk({pfx, "_ifid_inst"}, bus.ifid_instr,         32'h0);
    chk({pfx, "_ifid_pc4"},  bus.ifid_pc4,           32'h0);
    chk({pfx, "_ifid_vld"},  {31'd0, bus.ifid_valid}, 32'h0);
    chk({pfx, "_idex_ctrl"}, {20'd0, bus.idex_ctrl}, 32'h0);
    chk({pfx, "_idex_rt"},   {27'd0, bus.idex_rt},   32'h0);
    chk({pfx, "_idex_rd"},   {27'd0, bus.idex_rd},   32'h0);
    chk({pfx, "_idex_vld"},  {31'd0, bus.idex_valid}, 32'h0);
    chk({pfx, "_stall_cnt"}, {16'd0, bus.stall_cnt}, 32'h0);
    chk({pfx, "_flush_cnt"}, {16'd0, bus.flush_cnt}, 32'h0);
    chk({pfx, "_misalign"},  {31'd0, bus.misalign},  32'h0);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    bus.pc_write        = 1'b0;
    bus.ifid_write      = 1'b0;
    bus.stall           = 1'b0;
    bus.flush           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    bus.instr_if        = 32'h0;
    bus.id_ctrl         = 12'h0;
    bus.id_rt           = 5'd0;
    bus.id_rd           = 5'd0;

    step();
    step();
    chk_reset_state("rst0");

    // Sequential fetch of one instruction word.
    rst = 1'b0;
    bus.pc_write   = 1'b1;
    bus.ifid_write = 1'b1;
    bus.instr_if   = 32'h8C01_0004;
    bus.id_ctrl    = 12'h5A5;
    bus.id_rt      = 5'd3;
    bus.id_rd      = 5'd7;
    step();
    chk("fetch1_pc",       bus.pc,                  32'h4);
    chk("fetch1_ifid",     bus.ifid_instr,          32'h8C01_0004);
    chk("fetch1_pc4",      bus.ifid_pc4,            32'h4);
    chk("fetch1_vld",      {31'd0, bus.ifid_valid}, 32'h1);
    step();
    chk("fetch2_pc",       bus.pc,                  32'h8);
    chk("fetch2_idexctl",  {20'd0, bus.idex_ctrl},  32'h5A5);
    chk("fetch2_idexrt",   {27'd0, bus.idex_rt},    32'h3);
    chk("fetch2_idexrd",   {27'd0, bus.idex_rd},    32'h7);
    chk("fetch2_idexvld",  {31'd0, bus.idex_valid}, 32'h1);

    // Load-use stall at pc=8.
    bus.stall      = 1'b1;
    bus.pc_write   = 1'b0;
    bus.ifid_write = 1'b0;
    step();
    chk("lu_pc",        bus.pc,                  32'h8);
    chk("lu_ifid",      bus.ifid_instr,          32'h8C01_0004);
    chk("lu_pc4",       bus.ifid_pc4,            32'h8);
    chk("lu_idexvld",   {31'd0, bus.idex_valid}, 32'h0);
    chk("lu_idexctl",   {20'd0, bus.idex_ctrl},  32'h0);
    chk("lu_stallcnt",  {16'd0, bus.stall_cnt},  32'h1);

    // Taken branch to 0x40.
    bus.stall           = 1'b0;
    bus.pc_write        = 1'b1;
    bus.ifid_write      = 1'b1;
    bus.flush           = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0040;
    step();
    chk("br_pc",        bus.pc,                  32'h40);
    chk("br_ifid",      bus.ifid_instr,          32'h0);
    chk("br_pc4",       bus.ifid_pc4,            32'h0);
    chk("br_ifidvld",   {31'd0, bus.ifid_valid}, 32'h0);
    chk("br_idexvld",   {31'd0, bus.idex_valid}, 32'h0);
    chk("br_flushcnt",  {16'd0, bus.flush_cnt},  32'h1);

    // Stall and flush together: redirect to 0x80 is dropped.
    bus.stall           = 1'b1;
    bus.redirect_target = 32'h0000_0080;
    step();
    chk("sf_pc",        bus.pc,                  32'h40);
    chk("sf_flushcnt",  {16'd0, bus.flush_cnt},  32'h1);
    chk("sf_stallcnt",  {16'd0, bus.stall_cnt},  32'h2);
    chk("sf_idexvld",   {31'd0, bus.idex_valid}, 32'h0);

    // Redirect without flush is ignored; PC just advances.
    bus.stall           = 1'b0;
    bus.flush           = 1'b0;
    bus.redirect_target = 32'h0000_0100;
    step();
    chk("nf_pc",        bus.pc,                  32'h44);
    chk("nf_pc4",       bus.ifid_pc4,            32'h44);
    chk("nf_ifidvld",   {31'd0, bus.ifid_valid}, 32'h1);
    chk("nf_misalign",  {31'd0, bus.misalign},   32'h0);

    // Misaligned target 0x42 is truncated and flagged.
    bus.flush           = 1'b1;
    bus.redirect_target = 32'h0000_0042;
    step();
    chk("mis_pc",       bus.pc,                  32'h40);
    chk("mis_flag",     {31'd0, bus.misalign},   32'h1);
    chk("mis_flushcnt", {16'd0, bus.flush_cnt},  32'h2);

    // Misalign is sticky across normal cycles.
    bus.flush          = 1'b0;
    bus.redirect_valid = 1'b0;
    step();
    chk("sticky_pc",    bus.pc,                  32'h44);
    chk("sticky_flag",  {31'd0, bus.misalign},   32'h1);

    // PC wraparound from 0xFFFF_FFFC.
    bus.flush           = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    step();
    chk("wrap_pc0",     bus.pc,                  32'hFFFF_FFFC);
    chk("wrap_flushcnt", {16'd0, bus.flush_cnt}, 32'h3);
    bus.flush          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.instr_if       = 32'h1234_5678;
    step();
    chk("wrap_pc1",     bus.pc,                  32'h0);
    chk("wrap_pc4",     bus.ifid_pc4,            32'h0);
    chk("wrap_ifid",    bus.ifid_instr,          32'h1234_5678);
    chk("wrap_ifidvld", {31'd0, bus.ifid_valid}, 32'h1);
    bus.id_ctrl = 12'h3C3;
    bus.id_rd   = 5'd31;
    step();
    chk("lat_pc",       bus.pc,                  32'h4);
    chk("lat_idexctl",  {20'd0, bus.idex_ctrl},  32'h3C3);
    chk("lat_idexrd",   {27'd0, bus.idex_rd},    32'h1F);
    chk("lat_idexvld",  {31'd0, bus.idex_valid}, 32'h1);

    // Asynchronous reset in the middle of a stall run.
    bus.stall      = 1'b1;
    bus.pc_write   = 1'b0;
    bus.ifid_write = 1'b0;
    step();
    step();
    step();
    chk("pre_rst_stallcnt", {16'd0, bus.stall_cnt}, 32'h5);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_state("rst1");

    // Long stall saturates the counter; PC stays at reset value.
    rst = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
    end
    #1;
    chk("sat_stallcnt", {16'd0, bus.stall_cnt}, 32'hFFFF);
    chk("sat_pc",       bus.pc,                 32'h0);
    chk("sat_idexvld",  {31'd0, bus.idex_valid}, 32'h0);

    // Resume fetch; counters keep their values.
    bus.stall      = 1'b0;
    bus.pc_write   = 1'b1;
    bus.ifid_write = 1'b1;
    step();
    chk("end_pc",       bus.pc,                 32'h4);
    chk("end_stallcnt", {16'd0, bus.stall_cnt}, 32'hFFFF);
    chk("end_flushcnt", {16'd0, bus.flush_cnt}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipe_front_regs.md
PIPE_FRONT_REGS -- requirements
Module: pipe_front_regs

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0000, instruction word injected into IF/ID on flush.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 pc_write  input  1  1 = PC may advance; 0 = hold PC (load-use stall).
REQ-006 ifid_write  input  1  1 = IF/ID may load; 0 = hold IF/ID.
REQ-007 stall  input  1  1 = insert bubble into ID/EX.
REQ-008 flush  input  1  1 = squash wrong-path instruction in IF/ID and ID/EX.
REQ-009 redirect_valid  input  1  branch/jump target valid this cycle.
REQ-010 redirect_target  input  32  branch/jump target address.
REQ-011 instr_if  input  32  instruction fetched at current pc.
REQ-012 id_ctrl  input  12  decoded control bundle from ID.
REQ-013 id_rt, id_rd  input  5 each  register addresses from ID.
REQ-014 pc  output  32  current fetch address.
REQ-015 ifid_instr, ifid_pc4  output  32 each  IF/ID instruction and PC+4.
REQ-016 ifid_valid  output  1  IF/ID holds a real instruction.
REQ-017 idex_ctrl  output  12; idex_rt, idex_rd  output  5 each; idex_valid  output  1  ID/EX fields.
REQ-018 stall_cnt, flush_cnt  output  16 each  saturating event counters.
REQ-019 misalign  output  1  sticky flag: a taken redirect had target[1:0] != 0.

Function
REQ-020 All state SHALL update only on rising clk, except asynchronous reset.
REQ-021 PC priority, per cycle: stall=1 -> hold; else flush=1 and redirect_valid=1 -> pc <= {redirect_target[31:2],2'b00}; else pc_write=1 -> pc <= pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0); else hold.
REQ-022 Taken redirect with redirect_target[1:0] != 0 SHALL set misalign on the same edge; misalign clears only on reset.
REQ-023 IF/ID priority: stall=1 -> hold all IF/ID fields; else flush=1 -> ifid_instr <= NOP_INSTR, ifid_pc4 <= 0, ifid_valid <= 0; else ifid_write=1 -> ifid_instr <= instr_if, ifid_pc4 <= pc+4, ifid_valid <= 1; else hold.
REQ-024 ID/EX: stall=1 or flush=1 -> idex_ctrl <= 0, idex_rt <= 0, idex_rd <= 0, idex_valid <= 0 (bubble); else load id_ctrl, id_rt, id_rd, idex_valid <= ifid_valid.
REQ-025 Simultaneous stall and flush: stall SHALL win for PC and IF/ID (redirect ignored, not latched); ID/EX receives bubble.
REQ-026 redirect_valid=1 with flush=0 SHALL be ignored.
REQ-027 stall_cnt increments by 1 each cycle stall=1; flush_cnt increments each cycle flush=1 and stall=0; both saturate at 16'hFFFF.
REQ-028 Latency: instruction presented on instr_if appears on ifid_instr one cycle later and its control on idex_ctrl two cycles later, absent stall/flush.
REQ-029 No combinational path from any input to any output.

Reset
REQ-030 While rst=1: pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc4=0, ifid_valid=0, idex_ctrl=0, idex_rt=0, idex_rd=0, idex_valid=0, stall_cnt=0, flush_cnt=0, misalign=0.
REQ-031 Reset asserted mid-stall or mid-flush SHALL override all inputs immediately; first edge after deassertion follows REQ-021..REQ-027 normally.

Verification
REQ-032 Reset release, pc_write=ifid_write=1, instr_if=32'h8C01_0004 -> pc 0,4,8; ifid_instr=32'h8C01_0004, ifid_pc4=4, ifid_valid=1 after edge 1.
REQ-033 Load-use: stall=1, pc_write=0, ifid_write=0 for 1 cycle at pc=8 -> pc stays 8, IF/ID unchanged, idex_valid=0, idex_ctrl=0, stall_cnt=1.
REQ-034 Branch: flush=1, redirect_valid=1, redirect_target=32'h0000_0040 -> pc=32'h40, ifid_instr=NOP_INSTR, ifid_valid=0, idex_valid=0, flush_cnt=1.
REQ-035 stall=1 and flush=1 with target 32'h80 same cycle -> pc held, redirect dropped, flush_cnt unchanged, stall_cnt+1; target 32'h42 taken later -> pc=32'h40, misalign=1.
REQ-036 pc forced to 32'hFFFF_FFFC via redirect, then advance -> pc=0; 65536+ stall cycles -> stall_cnt=16'hFFFF; rst pulse mid-sequence -> all outputs per REQ-030.
